wallace_mult_checker: RTL and testbench

- Synthesizable self-checking response side for the W×W Wallace tree multiplier.
- Drives every operand pair to the multiplier under test, one per cycle.
- Captures the returned product and compares it against an internal reference product, delayed to match the DUT latency.
- Reports a pass/fail verdict, an error count, and the first failing pair. It sits beside the multiplier on the board or in a top-level bench, replacing hand-written stimulus.

---
 rtl/wallace_mult_checker_if.sv | 29 ++
 rtl/wallace_mult_checker.sv | 154 +++++++++++++++
 tb/tb_wallace_mult_checker.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/wallace_mult_checker_if.sv
// Signal bundle between the multiplier checker (master) and the multiplier under test / host (slave).
interface wallace_mult_checker_if #(
  parameter int WIDTH = 5,
  parameter int ERR_W = 16
);
  logic                 start;
  logic [WIDTH-1:0]     a_out;
  logic [WIDTH-1:0]     b_out;
  logic [2*WIDTH-1:0]   product_in;
  logic                 busy;
  logic                 done;
  logic                 pass;
  logic [ERR_W-1:0]     err_count;
  logic [WIDTH-1:0]     first_err_a;
  logic [WIDTH-1:0]     first_err_b;
  logic                 first_err_valid;

  modport master (
    input  start, product_in,
    output a_out, b_out, busy, done, pass, err_count,
           first_err_a, first_err_b, first_err_valid
  );

  modport slave (
    output start, product_in,
    input  a_out, b_out, busy, done, pass, err_count,
           first_err_a, first_err_b, first_err_valid
  );
endinterface

// File: rtl/wallace_mult_checker.sv
// Exhaustive sweep driver and response checker for a WIDTH x WIDTH unsigned multiplier,
// comparing each returned product against a reference delayed by the multiplier latency.
module wallace_mult_checker #(
  parameter int WIDTH       = 5,
  parameter int DUT_LATENCY = 0,
  parameter int ERR_W       = 16
) (
  input logic                    clk,
  input logic                    rst,
  wallace_mult_checker_if.master bus
);
  localparam int PW = 2 * WIDTH;
  localparam int LW = (DUT_LATENCY > 1) ? $clog2(DUT_LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, DRIVE, FLUSH, DONE} state_t;

  state_t           r_state;
  logic [PW-1:0]    r_idx;
  logic [LW-1:0]    r_flush_cnt;
  logic             r_busy;
  logic             r_done;
  logic             r_pass;
  logic [ERR_W-1:0] r_err;
  logic [WIDTH-1:0] r_fa;
  logic [WIDTH-1:0] r_fb;
  logic             r_fv;

  logic [WIDTH-1:0] w_a_p0, w_b_p0, w_a_cmp, w_b_cmp;
  logic [PW-1:0]    w_exp_p0, w_exp_cmp;
  logic             w_vld_p0, w_vld_cmp;
  logic             w_mismatch, w_last;
  logic [ERR_W-1:0] w_err_next;

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Stage p0: reference product of the pair currently presented to the multiplier
  assign w_a_p0   = r_idx[PW-1:WIDTH];
  assign w_b_p0   = r_idx[WIDTH-1:0];
  assign w_exp_p0 = PW'(w_a_p0) * PW'(w_b_p0);
  assign w_vld_p0 = (r_state == DRIVE);

  if (DUT_LATENCY == 0) begin : g_comb
    assign w_a_cmp   = w_a_p0;
    assign w_b_cmp   = w_b_p0;
    assign w_exp_cmp = w_exp_p0;
    assign w_vld_cmp = w_vld_p0;
  end else begin : g_pipe
    logic [WIDTH-1:0]       r_a_pn   [DUT_LATENCY];
    logic [WIDTH-1:0]       r_b_pn   [DUT_LATENCY];
    logic [PW-1:0]          r_exp_pn [DUT_LATENCY];
    logic [DUT_LATENCY-1:0] r_vld_pn;

    // Stages p1..pN: reference travels alongside the multiplier's internal registers
    always_ff @(posedge clk) begin
      r_a_pn[0]   <= w_a_p0;
      r_b_pn[0]   <= w_b_p0;
      r_exp_pn[0] <= w_exp_p0;
      for (int k = 1; k < DUT_LATENCY; k++) begin
        r_a_pn[k]   <= r_a_pn[k-1];
        r_b_pn[k]   <= r_b_pn[k-1];
        r_exp_pn[k] <= r_exp_pn[k-1];
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        r_vld_pn <= '0;
      end else begin
        r_vld_pn[0] <= w_vld_p0;
        for (int k = 1; k < DUT_LATENCY; k++) r_vld_pn[k] <= r_vld_pn[k-1];
      end
    end

    assign w_a_cmp   = r_a_pn[DUT_LATENCY-1];
    assign w_b_cmp   = r_b_pn[DUT_LATENCY-1];
    assign w_exp_cmp = r_exp_pn[DUT_LATENCY-1];
    assign w_vld_cmp = r_vld_pn[DUT_LATENCY-1];
  end

  // Compare stage: the verdict at the last slot must include a mismatch on that same edge
  assign w_mismatch = w_vld_cmp && (bus.product_in != w_exp_cmp);
  assign w_err_next = w_mismatch ? sat_inc(r_err) : r_err;
  assign w_last     = ((r_state == DRIVE) && (&r_idx) && (DUT_LATENCY == 0)) ||
                      ((r_state == FLUSH) && (r_flush_cnt == '0));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_idx       <= '0;
      r_flush_cnt <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_err       <= '0;
      r_fa        <= '0;
      r_fb        <= '0;
      r_fv        <= 1'b0;
    end else begin
      if (w_mismatch) begin
        r_err <= w_err_next;
        if (!r_fv) begin
          r_fa <= w_a_cmp;
          r_fb <= w_b_cmp;
          r_fv <= 1'b1;
        end
      end
      case (r_state)
        IDLE, DONE: begin
          if (bus.start) begin
            r_state <= DRIVE;
            r_idx   <= '0;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
            r_err   <= '0;
            r_fa    <= '0;
            r_fb    <= '0;
            r_fv    <= 1'b0;
          end
        end
        DRIVE: begin
          if (&r_idx) begin
            r_state     <= FLUSH;
            r_flush_cnt <= LW'(DUT_LATENCY - 1);
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        FLUSH: begin
          if (r_flush_cnt != '0) r_flush_cnt <= r_flush_cnt - 1'b1;
        end
        default: r_state <= IDLE;
      endcase
      if (w_last) begin
        r_state <= DONE;
        r_busy  <= 1'b0;
        r_done  <= 1'b1;
        r_pass  <= (w_err_next == '0);
      end
    end
  end

  assign bus.a_out           = r_idx[PW-1:WIDTH];
  assign bus.b_out           = r_idx[WIDTH-1:0];
  assign bus.busy            = r_busy;
  assign bus.done            = r_done;
  assign bus.pass            = r_pass;
  assign bus.err_count       = r_err;
  assign bus.first_err_a     = r_fa;
  assign bus.first_err_b     = r_fb;
  assign bus.first_err_valid = r_fv;
endmodule

// File: tb/tb_wallace_mult_checker.sv
// Bench for the multiplier checker: two checker instances (latency 0 and 2) driving modelled
// multipliers with selectable faults, checked against a sweep-level behavioural model.
module tb_wallace_mult_checker;
  localparam int W = 5;
  localparam int N = 1 << (2 * W);

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  always #5 clk = ~clk;

  wallace_mult_checker_if #(.WIDTH(W), .ERR_W(16)) ifA ();
  wallace_mult_checker_if #(.WIDTH(W), .ERR_W(8))  ifB ();

  wallace_mult_checker #(.WIDTH(W), .DUT_LATENCY(0), .ERR_W(16)) u_chk0 (.clk(clk), .rst(rst), .bus(ifA));
  wallace_mult_checker #(.WIDTH(W), .DUT_LATENCY(2), .ERR_W(8))  u_chk2 (.clk(clk), .rst(rst), .bus(ifB));

  int checks = 0;
  int failures = 0;
  int mode = 0;   // 0 ok, 1 bit0 stuck low, 2 a*b+1, 3 random faults, 4 A fed by a 2-stage multiplier
  bit             bad   [N];
  logic [2*W-1:0] xmask [N];
  logic [2*W-1:0] pa_comb, pa_q1, pa_q2, pb_comb, pb_q1, pb_q2;

  function automatic logic [2*W-1:0] faulty(input int m, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] p;
    int idx;
    p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    idx = int'({a, b});
    case (m)
      1: p[0] = 1'b0;
      2: p = p + 1'b1;
      3: if (bad[idx]) p = p ^ xmask[idx];
      default: ;
    endcase
    return p;
  endfunction

  always_comb pa_comb = faulty(mode, ifA.a_out, ifA.b_out);
  always_comb pb_comb = faulty((mode == 4) ? 0 : mode, ifB.a_out, ifB.b_out);
  always_ff @(posedge clk) begin
    pa_q1 <= {{W{1'b0}}, ifA.a_out} * {{W{1'b0}}, ifA.b_out};
    pa_q2 <= pa_q1;
    pb_q1 <= pb_comb;
    pb_q2 <= pb_q1;
  end
  assign ifA.product_in = (mode == 4) ? pa_q2 : pa_comb;
  assign ifB.product_in = pb_q2;
  assign ifA.start = start;
  assign ifB.start = start;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Sweep-level model: count every pair whose returned product differs from a*b.
  task automatic predict(input int m, output int cnt, output int fa, output int fb);
    int a, b;
    cnt = 0; fa = 0; fb = 0;
    for (int i = 0; i < N; i++) begin
      a = i / (1 << W);
      b = i % (1 << W);
      if (int'(faulty(m, a[W-1:0], b[W-1:0])) != a * b) begin
        if (cnt == 0) begin fa = a; fb = b; end
        cnt++;
      end
    end
  endtask

  task automatic check_idle(input string tag);
    chk({tag, " A outs"}, {ifA.busy, ifA.done, ifA.pass, ifA.err_count, ifA.first_err_valid,
                           ifA.first_err_a, ifA.first_err_b, ifA.a_out, ifA.b_out}, 0);
    chk({tag, " B outs"}, {ifB.busy, ifB.done, ifB.pass, ifB.err_count, ifB.first_err_valid,
                           ifB.first_err_a, ifB.first_err_b, ifB.a_out, ifB.b_out}, 0);
  endtask

  task automatic cycle_check(input string tag, input int i);
    int idx;
    logic [2*W-1:0] iv;
    logic [2*W+1:0] exp_a, exp_b;
    idx = (i < N) ? i : N - 1;
    iv = idx[2*W-1:0];
    exp_a = {(i < N), (i >= N), iv};
    exp_b = {(i < N + 2), (i >= N + 2), iv};
    chk({tag, " A cycle"}, {ifA.busy, ifA.done, ifA.a_out, ifA.b_out}, exp_a);
    chk({tag, " B cycle"}, {ifB.busy, ifB.done, ifB.a_out, ifB.b_out}, exp_b);
  endtask

  task automatic sweep(input int m, input int pulse_at, input string tag);
    int cnt, fa, fb, cntb;
    mode = m;
    @(negedge clk);
    start = 1'b1;
    for (int i = 0; i <= N + 2; i++) begin
      @(negedge clk);
      start = (i == pulse_at);
      cycle_check(tag, i);
    end
    start = 1'b0;
    if (m != 4) begin
      predict(m, cnt, fa, fb);
      cntb = (cnt > 255) ? 255 : cnt;
      chk({tag, " A pass"}, ifA.pass, (cnt == 0));
      chk({tag, " A err"}, ifA.err_count, cnt);
      chk({tag, " A first"}, {ifA.first_err_valid, ifA.first_err_a, ifA.first_err_b},
          {(cnt != 0), fa[W-1:0], fb[W-1:0]});
      chk({tag, " B pass"}, ifB.pass, (cnt == 0));
      chk({tag, " B err"}, ifB.err_count, cntb);
      chk({tag, " B first"}, {ifB.first_err_valid, ifB.first_err_a, ifB.first_err_b},
          {(cnt != 0), fa[W-1:0], fb[W-1:0]});
    end else begin
      chk({tag, " A pass"}, ifA.pass, 0);
      chk({tag, " A err nonzero"}, (ifA.err_count != 0), 1);
      chk({tag, " A first valid"}, ifA.first_err_valid, 1);
      chk({tag, " B pass"}, ifB.pass, 1);
      chk({tag, " B err"}, ifB.err_count, 0);
    end
  endtask

  task automatic sweep_reset(input int m, input int at);
    mode = m;
    @(negedge clk);
    start = 1'b1;
    for (int i = 0; i <= at; i++) begin
      @(negedge clk);
      start = 1'b0;
      cycle_check("rstsw", i);
    end
    rst = 1'b1;
    start = 1'b1;
    @(negedge clk);
    check_idle("midrst");
    rst = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check_idle("after rst");
  endtask

  task automatic randomize_faults(input int maxn);
    int n, idx;
    for (int i = 0; i < N; i++) begin bad[i] = 1'b0; xmask[i] = '0; end
    n = $urandom_range(1, maxn);
    for (int k = 0; k < n; k++) begin
      idx = $urandom_range(0, N - 1);
      bad[idx] = 1'b1;
      xmask[idx] = (2*W)'($urandom_range(1, N - 1));
    end
  endtask

  initial begin
    int cnt, fa, fb;
    for (int i = 0; i < N; i++) begin bad[i] = 1'b0; xmask[i] = '0; end
    repeat (3) @(negedge clk);
    check_idle("reset");
    rst = 1'b0;
    @(negedge clk);
    check_idle("idle");

    predict(0, cnt, fa, fb);
    chk("model m0 count", cnt, 0);
    predict(1, cnt, fa, fb);
    chk("model m1 count", cnt, 256);
    chk("model m1 first", {fa[7:0], fb[7:0]}, {8'd1, 8'd1});
    predict(2, cnt, fa, fb);
    chk("model m2 count", cnt, 1024);
    chk("model m2 first", {fa[7:0], fb[7:0]}, 0);

    sweep(0, -1, "good");
    sweep(1, -1, "bit0");
    sweep(2, 300, "plus1");
    randomize_faults(40);
    sweep(3, $urandom_range(10, 1000), "rand0");
    randomize_faults(600);
    sweep(3, -1, "rand1");
    sweep(4, -1, "latmis");
    sweep_reset(2, 500);
    sweep(0, -1, "fresh");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
